// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bundles the MEM-side inputs, the WB-stage write controls,
// the two ID read ports and the debug read port of the write-back/register-file block.
//   slave  : the register file (wb_regfile)
//   master : the pipeline driving it
// Signals:
//   stall_wb, flush_wb                  MEM/WB register hold / bubble
//   RegWrite_mem, MemtoReg_mem,
//   RegWriteAddr_mem, AluResult_mem,
//   MemData_mem                         MEM-stage payload
//   RegWrite_wb, RegWriteAddr_wb,
//   RegWriteData_wb                     WB-stage write controls (to forwarding)
//   RsAddr_id/RsData_id,
//   RtAddr_id/RtData_id                 ID read ports (write-first bypass)
//   DbgAddr/DbgData                     debug read port (array only)
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              stall_wb;
  logic              flush_wb;
  logic              RegWrite_mem;
  logic              MemtoReg_mem;
  logic [ADDR_W-1:0] RegWriteAddr_mem;
  logic [DATA_W-1:0] AluResult_mem;
  logic [DATA_W-1:0] MemData_mem;
  logic              RegWrite_wb;
  logic [ADDR_W-1:0] RegWriteAddr_wb;
  logic [DATA_W-1:0] RegWriteData_wb;
  logic [ADDR_W-1:0] RsAddr_id;
  logic [ADDR_W-1:0] RtAddr_id;
  logic [DATA_W-1:0] RsData_id;
  logic [DATA_W-1:0] RtData_id;
  logic [ADDR_W-1:0] DbgAddr;
  logic [DATA_W-1:0] DbgData;

  modport slave (
    input  stall_wb, flush_wb,
    input  RegWrite_mem, MemtoReg_mem, RegWriteAddr_mem, AluResult_mem, MemData_mem,
    output RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb,
    input  RsAddr_id, RtAddr_id,
    output RsData_id, RtData_id,
    input  DbgAddr,
    output DbgData
  );

  modport master (
    output stall_wb, flush_wb,
    output RegWrite_mem, MemtoReg_mem, RegWriteAddr_mem, AluResult_mem, MemData_mem,
    input  RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb,
    output RsAddr_id, RtAddr_id,
    input  RsData_id, RtData_id,
    output DbgAddr,
    input  DbgData
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage of the pipeline. Holds the MEM/WB pipeline
// register, selects the write-back data and commits it to a 2^ADDR_W-entry
// register file (entry 0 reads as zero). Two ID read ports return the value
// being written this cycle (write-first bypass); a debug port reads the array.
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset (clears MEM/WB and the array)
//   bus    wb_regfile_if.slave: MEM payload in, WB controls out,
//          ID read ports A/B, debug read port
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_regfile_if.slave   bus
);

  localparam int unsigned numRegs = 32'(1) << ADDR_W;

  typedef struct packed {
    logic              regWrite;
    logic              memtoReg;
    logic [ADDR_W-1:0] regWriteAddr;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] memData;
  } memWb_t;

  memWb_t            memWbQ;
  memWb_t            memWbD;
  logic [DATA_W-1:0] wbData;
  logic              arrayWe;
  logic [DATA_W-1:0] regArray [numRegs];

  // MEM/WB next value: flush beats stall, stall holds, otherwise capture MEM
  always_comb begin
    memWbD = memWbQ;
    if (bus.flush_wb) begin
      memWbD = '0;
    end else if (!bus.stall_wb) begin
      memWbD.regWrite     = bus.RegWrite_mem;
      memWbD.memtoReg     = bus.MemtoReg_mem;
      memWbD.regWriteAddr = bus.RegWriteAddr_mem;
      memWbD.aluResult    = bus.AluResult_mem;
      memWbD.memData      = bus.MemData_mem;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memWbQ <= '0;
    end else begin
      memWbQ <= memWbD;
    end
  end

  // Write-back data select and array write enable (entry 0 is never written)
  assign wbData  = memWbQ.memtoReg ? memWbQ.memData : memWbQ.aluResult;
  assign arrayWe = memWbQ.regWrite && (memWbQ.regWriteAddr != '0);

  // Register array; a stalled WB instruction rewrites the same value each edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regArray <= '{default: '0};
    end else if (arrayWe) begin
      regArray[memWbQ.regWriteAddr] <= wbData;
    end
  end

  // WB-stage controls seen by the forwarding selectors
  assign bus.RegWrite_wb     = memWbQ.regWrite;
  assign bus.RegWriteAddr_wb = memWbQ.regWriteAddr;
  assign bus.RegWriteData_wb = wbData;

  // ID read ports: zero for r0, then write-first bypass, then array
  assign bus.RsData_id = (bus.RsAddr_id == '0) ? '0 :
                         (memWbQ.regWrite && (memWbQ.regWriteAddr == bus.RsAddr_id)) ? wbData :
                         regArray[bus.RsAddr_id];

  assign bus.RtData_id = (bus.RtAddr_id == '0) ? '0 :
                         (memWbQ.regWrite && (memWbQ.regWriteAddr == bus.RtAddr_id)) ? wbData :
                         regArray[bus.RtAddr_id];

  // Debug port shows committed array contents only
  assign bus.DbgData = (bus.DbgAddr == '0) ? '0 : regArray[bus.DbgAddr];

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scenarios plus randomized traffic against an
// architectural model (register array + one in-flight WB write).
module tb_wb_regfile;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nChecks = 0;
  int nPass   = 0;

  // Architectural model: committed registers plus the pending WB write
  logic [31:0] mArr [32];
  logic        mRw;
  logic [4:0]  mAddr;
  logic [31:0] mData;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mArr[i] = 32'h0;
      mRw = 1'b0; mAddr = 5'd0; mData = 32'h0;
    end else begin
      if (mRw && mAddr != 5'd0) mArr[mAddr] = mData;
      if (bus.flush_wb) begin
        mRw = 1'b0; mAddr = 5'd0; mData = 32'h0;
      end else if (!bus.stall_wb) begin
        mRw   = bus.RegWrite_mem;
        mAddr = bus.RegWriteAddr_mem;
        mData = bus.MemtoReg_mem ? bus.MemData_mem : bus.AluResult_mem;
      end
    end
  end

  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (mRw && mAddr == a) return mData;
    return mArr[a];
  endfunction

  function automatic logic [31:0] expDbg(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    return mArr[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("RegWrite_wb",     32'(bus.RegWrite_wb),     32'(mRw));
    check("RegWriteAddr_wb", 32'(bus.RegWriteAddr_wb), 32'(mAddr));
    check("RegWriteData_wb", bus.RegWriteData_wb,      mData);
    check("RsData_id",       bus.RsData_id,            expRead(bus.RsAddr_id));
    check("RtData_id",       bus.RtData_id,            expRead(bus.RtAddr_id));
    check("DbgData",         bus.DbgData,              expDbg(bus.DbgAddr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic memOp(input logic rw, input logic mtr, input logic [4:0] a,
                       input logic [31:0] alu, input logic [31:0] md);
    bus.RegWrite_mem     = rw;
    bus.MemtoReg_mem     = mtr;
    bus.RegWriteAddr_mem = a;
    bus.AluResult_mem    = alu;
    bus.MemData_mem      = md;
  endtask

  task automatic idle();
    memOp(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [4:0] rndAddr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    bus.stall_wb = 1'b0;
    bus.flush_wb = 1'b0;
    bus.RsAddr_id = 5'd0;
    bus.RtAddr_id = 5'd0;
    bus.DbgAddr   = 5'd0;
    idle();

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst RegWrite_wb", 32'(bus.RegWrite_wb), 32'h0);
    check("rst RegWriteData_wb", bus.RegWriteData_wb, 32'h0);
    tick();
    rst_n = 1'b1;

    // ALU result write to r5: bypass after N, array after N+1
    memOp(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    bus.RsAddr_id = 5'd5;
    tick();
    idle();
    @(negedge clk);
    check("r5 RegWriteData_wb", bus.RegWriteData_wb, 32'h1234);
    check("r5 bypass RsData", bus.RsData_id, 32'h1234);
    tick();
    bus.DbgAddr = 5'd5;
    @(negedge clk);
    check("r5 DbgData", bus.DbgData, 32'h1234);

    // Memory data select into r9
    memOp(1'b1, 1'b1, 5'd9, 32'h1, 32'hDEADBEEF);
    tick();
    idle();
    tick();
    bus.DbgAddr = 5'd9;
    @(negedge clk);
    check("r9 DbgData", bus.DbgData, 32'hDEADBEEF);

    // Write to r0 must neither bypass nor commit
    memOp(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
    bus.RsAddr_id = 5'd0;
    bus.RtAddr_id = 5'd0;
    bus.DbgAddr   = 5'd0;
    tick();
    idle();
    @(negedge clk);
    check("r0 wb RsData", bus.RsData_id, 32'h0);
    check("r0 wb RtData", bus.RtData_id, 32'h0);
    tick();
    @(negedge clk);
    check("r0 after RsData", bus.RsData_id, 32'h0);
    check("r0 after DbgData", bus.DbgData, 32'h0);

    // Stall holds WB and blocks MEM capture; flush wins over stall
    memOp(1'b1, 1'b0, 5'd7, 32'hA5, 32'h0);
    tick();
    bus.stall_wb = 1'b1;
    memOp(1'b1, 1'b0, 5'd8, 32'h88, 32'h0);
    bus.DbgAddr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("stall addr_wb", 32'(bus.RegWriteAddr_wb), 32'd7);
      check("stall data_wb", bus.RegWriteData_wb, 32'hA5);
      check("stall r7 Dbg", bus.DbgData, 32'hA5);
    end
    bus.stall_wb = 1'b0;
    tick();
    @(negedge clk);
    check("unstall addr_wb", 32'(bus.RegWriteAddr_wb), 32'd8);
    check("unstall data_wb", bus.RegWriteData_wb, 32'h88);
    idle();
    bus.stall_wb = 1'b1;
    bus.flush_wb = 1'b1;
    bus.DbgAddr  = 5'd8;
    tick();
    bus.stall_wb = 1'b0;
    bus.flush_wb = 1'b0;
    @(negedge clk);
    check("flush RegWrite_wb", 32'(bus.RegWrite_wb), 32'h0);
    check("flush r8 Dbg", bus.DbgData, 32'h88);

    // Both ports on r3: array value, then bypassed WB value
    memOp(1'b1, 1'b0, 5'd3, 32'h11, 32'h0);
    tick();
    idle();
    tick();
    bus.RsAddr_id = 5'd3;
    bus.RtAddr_id = 5'd3;
    @(negedge clk);
    check("r3 array RsData", bus.RsData_id, 32'h11);
    check("r3 array RtData", bus.RtData_id, 32'h11);
    memOp(1'b1, 1'b0, 5'd3, 32'h77, 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("r3 bypass RsData", bus.RsData_id, 32'h77);
    check("r3 bypass RtData", bus.RtData_id, 32'h77);

    // Randomized traffic, including rare stalls, flushes and resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      memOp(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rndAddr(),
            $urandom(), $urandom());
      bus.stall_wb  = ($urandom_range(0, 5) == 0);
      bus.flush_wb  = ($urandom_range(0, 11) == 0);
      bus.RsAddr_id = rndAddr();
      bus.RtAddr_id = rndAddr();
      bus.DbgAddr   = rndAddr();
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    bus.stall_wb = 1'b0;
    bus.flush_wb = 1'b0;

    // Reset mid-run after writes
    memOp(1'b1, 1'b0, 5'd5, 32'h5555, 32'h0);
    tick();
    idle();
    tick();
    bus.RsAddr_id = 5'd5;
    bus.RtAddr_id = 5'd5;
    bus.DbgAddr   = 5'd5;
    @(negedge clk);
    check("pre-reset r5", bus.DbgData, 32'h5555);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset RsData", bus.RsData_id, 32'h0);
    check("reset RtData", bus.RtData_id, 32'h0);
    check("reset DbgData", bus.DbgData, 32'h0);
    check("reset RegWrite_wb", 32'(bus.RegWrite_wb), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post-reset r5", bus.RsData_id, 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
